// File: rtl/reg_scoreboard_pkg.sv
// Shared types and defaults for the register scoreboard.
// Optional feature macro: SCBD_WB_BYPASS_EN (see reg_scoreboard.sv).
package reg_scoreboard_pkg;

  localparam int unsigned NUM_REGS          = 32;
  localparam int unsigned RADDR_W           = 5;
  localparam int unsigned SCBD_MAX_INFLIGHT = 2;

  typedef logic [RADDR_W-1:0] raddr_t;

  typedef struct packed {
    logic   valid;
    logic   we_rd;
    raddr_t rd_addr;
  } s_scbd_issue_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight rd writes and stalls decode on RAW hazards or a full window.
// Optional macro SCBD_WB_BYPASS_EN: a writeback retiring the last pending write clears the source hazard in the same cycle.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = SCBD_MAX_INFLIGHT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid_i,
  input  logic                issue_ready_i,
  input  logic                issue_we_rd_i,
  input  logic [RADDR_W-1:0]  issue_rd_addr_i,
  input  logic                flush_i,
  input  logic [RADDR_W-1:0]  rs1_addr_i,
  input  logic                rs1_used_i,
  input  logic [RADDR_W-1:0]  rs2_addr_i,
  input  logic                rs2_used_i,
  input  logic                wb_we_rd_i,
  input  logic [RADDR_W-1:0]  wb_rd_addr_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned      CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [CNT_W-1:0]    total_q, total_d;
  logic                err_q, err_d;

  s_scbd_issue_t       issue;
  logic                wb_hit, wb_ok, wb_orphan;
  logic                byp1, byp2, haz1, haz2, full, iss;
  logic [NUM_REGS-1:0] iss_oh, wb_oh;

  // A flushed slot is treated as a NOP for both stall and issue.
  assign issue.valid   = issue_valid_i & ~flush_i;
  assign issue.we_rd   = issue_we_rd_i;
  assign issue.rd_addr = issue_rd_addr_i;

  assign wb_hit    = wb_we_rd_i & (wb_rd_addr_i != '0);
  assign wb_ok     = wb_hit & (cnt_q[wb_rd_addr_i] != '0);
  assign wb_orphan = wb_hit & ~wb_ok;

`ifdef SCBD_WB_BYPASS_EN
  assign byp1 = wb_hit & (wb_rd_addr_i == rs1_addr_i) & (cnt_q[rs1_addr_i] == CNT_ONE);
  assign byp2 = wb_hit & (wb_rd_addr_i == rs2_addr_i) & (cnt_q[rs2_addr_i] == CNT_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign haz1 = rs1_used_i & (rs1_addr_i != '0) & (cnt_q[rs1_addr_i] != '0) & ~byp1;
  assign haz2 = rs2_used_i & (rs2_addr_i != '0) & (cnt_q[rs2_addr_i] != '0) & ~byp2;
  assign full = (total_q == CNT_MAX) | (issue.we_rd & (cnt_q[issue.rd_addr] == CNT_MAX));

  // Independent of issue_ready_i so decode can use it without a loop.
  assign stall_o = issue.valid & (haz1 | haz2 | full);

  assign iss = issue.valid & issue_ready_i & ~stall_o & issue.we_rd & (issue.rd_addr != '0);

  assign iss_oh = iss   ? (NUM_REGS'(1) << issue.rd_addr) : '0;
  assign wb_oh  = wb_ok ? (NUM_REGS'(1) << wb_rd_addr_i)  : '0;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (iss_oh[r] & ~wb_oh[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (~iss_oh[r] & wb_oh[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_comb begin
    total_d = total_q;
    unique case ({iss, wb_ok})
      2'b10:   total_d = total_q + CNT_ONE;
      2'b01:   total_d = total_q - CNT_ONE;
      default: total_d = total_q;
    endcase
    err_d = err_q | wb_orphan;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '{default: '0};
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pending_o[r] = (cnt_q[r] != '0);
    end
  end

  assign busy_o = (total_q != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, reset sequences and a randomized run against a count-based model.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int MAXI = 2;
`ifdef SCBD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid_i = 1'b0, issue_ready_i = 1'b0, issue_we_rd_i = 1'b0;
  logic [4:0]  issue_rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0;
  logic        rs1_used_i = 1'b0, rs2_used_i = 1'b0;
  logic        wb_we_rd_i = 1'b0;
  logic [4:0]  wb_rd_addr_i = '0;
  logic        stall_o, busy_o, err_o;
  logic [31:0] pending_o;

  int n_checks = 0;
  int n_pass   = 0;

  reg_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_ready_i(issue_ready_i),
    .issue_we_rd_i(issue_we_rd_i), .issue_rd_addr_i(issue_rd_addr_i),
    .flush_i(flush_i),
    .rs1_addr_i(rs1_addr_i), .rs1_used_i(rs1_used_i),
    .rs2_addr_i(rs2_addr_i), .rs2_used_i(rs2_used_i),
    .wb_we_rd_i(wb_we_rd_i), .wb_rd_addr_i(wb_rd_addr_i),
    .stall_o(stall_o), .pending_o(pending_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, ir, iwe;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        wwe;
    logic [4:0]  wrd;
    logic        e_stall;
    logic [31:0] e_pend;
    logic        e_busy, e_err;
  } vec_t;

  vec_t vecs[$];

  // reference model: plain integer counts per register
  int mcnt [32];
  int mtot;
  bit merr;

  function automatic vec_t mk(input logic iv, ir, iwe, input int ird, input logic fl,
                              input int rs1, input logic u1, input int rs2, input logic u2,
                              input logic wwe, input int wrd,
                              input logic st, input logic [31:0] pend, input logic bsy, input logic er);
    vec_t v;
    v.iv = iv; v.ir = ir; v.iwe = iwe; v.ird = 5'(ird); v.fl = fl;
    v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
    v.wwe = wwe; v.wrd = 5'(wrd);
    v.e_stall = st; v.e_pend = pend; v.e_busy = bsy; v.e_err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic drive(input logic iv, ir, iwe, input logic [4:0] ird, input logic fl,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic wwe, input logic [4:0] wrd);
    issue_valid_i = iv; issue_ready_i = ir; issue_we_rd_i = iwe; issue_rd_addr_i = ird;
    flush_i = fl; rs1_addr_i = rs1; rs1_used_i = u1; rs2_addr_i = rs2; rs2_used_i = u2;
    wb_we_rd_i = wwe; wb_rd_addr_i = wrd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    idle();
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic bit m_stall();
    bit wbv, h1, h2, fullb;
    wbv = wb_we_rd_i && (wb_rd_addr_i != 0);
    h1 = rs1_used_i && (rs1_addr_i != 0) && (mcnt[rs1_addr_i] > 0) &&
         !(BYP && wbv && (wb_rd_addr_i == rs1_addr_i) && (mcnt[rs1_addr_i] == 1));
    h2 = rs2_used_i && (rs2_addr_i != 0) && (mcnt[rs2_addr_i] > 0) &&
         !(BYP && wbv && (wb_rd_addr_i == rs2_addr_i) && (mcnt[rs2_addr_i] == 1));
    fullb = (mtot == MAXI) || (issue_we_rd_i && (mcnt[issue_rd_addr_i] == MAXI));
    return issue_valid_i && !flush_i && (h1 || h2 || fullb);
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    mtot = 0;
    merr = 0;
  endtask

  // apply the current inputs to the model as the coming clock edge would
  task automatic m_step();
    bit st, iss, wbv, wok;
    if (!rst) begin
      m_clear();
    end else begin
      st  = m_stall();
      iss = issue_valid_i && issue_ready_i && !st && !flush_i && issue_we_rd_i && (issue_rd_addr_i != 0);
      wbv = wb_we_rd_i && (wb_rd_addr_i != 0);
      wok = wbv && (mcnt[wb_rd_addr_i] > 0);
      if (wbv && !wok) merr = 1;
      if (iss) begin mcnt[issue_rd_addr_i]++; mtot++; end
      if (wok) begin mcnt[wb_rd_addr_i]--; mtot--; end
    end
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] p;
    for (int r = 0; r < 32; r++) p[r] = (mcnt[r] != 0);
    return p;
  endfunction

  initial begin
    vec_t v;
    int pend_q[$];

    //            iv ir we rd fl rs1 u1 rs2 u2 wwe wrd  stall    pend       busy err
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 0));
    vecs.push_back(mk(1,1,1,5, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 0));
    vecs.push_back(mk(1,1,0,0, 0, 5,1, 0,0, 0,0,  1,       32'h20,    1, 0));
    vecs.push_back(mk(1,1,0,0, 0, 5,1, 0,0, 1,5,  !BYP,    32'h20,    1, 0));
    vecs.push_back(mk(1,1,0,0, 0, 5,1, 0,0, 0,0,  0,       32'h0,     0, 0));
    vecs.push_back(mk(1,1,1,5, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 0));
    vecs.push_back(mk(1,1,0,0, 0, 0,0, 5,1, 0,0,  1,       32'h20,    1, 0));
    vecs.push_back(mk(1,1,0,0, 0, 5,0, 5,0, 0,0,  0,       32'h20,    1, 0));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 1,5,  0,       32'h20,    1, 0));
    vecs.push_back(mk(1,1,1,1, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 0));
    vecs.push_back(mk(1,1,1,2, 0, 0,0, 0,0, 0,0,  0,       32'h2,     1, 0));
    vecs.push_back(mk(1,1,1,3, 0, 0,0, 0,0, 0,0,  1,       32'h6,     1, 0));
    vecs.push_back(mk(1,1,1,3, 0, 0,0, 0,0, 1,1,  1,       32'h6,     1, 0));
    vecs.push_back(mk(1,1,1,3, 0, 0,0, 0,0, 0,0,  0,       32'h4,     1, 0));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 1,2,  0,       32'hC,     1, 0));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 1,3,  0,       32'h8,     1, 0));
    vecs.push_back(mk(1,1,1,7, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 0));
    vecs.push_back(mk(1,1,1,7, 0, 0,0, 0,0, 1,7,  0,       32'h80,    1, 0));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 0,0,  0,       32'h80,    1, 0));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 1,7,  0,       32'h80,    1, 0));
    vecs.push_back(mk(1,1,1,9, 1, 0,0, 0,0, 0,0,  0,       32'h0,     0, 0));
    vecs.push_back(mk(1,1,1,0, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 0));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 0));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 1,4,  0,       32'h0,     0, 0));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 1));
    vecs.push_back(mk(1,1,1,9, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 1));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 0,0,  0,       32'h200,   1, 1));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 1,9,  0,       32'h200,   1, 1));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 1));
    vecs.push_back(mk(1,0,1,6, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 1));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 0,0,  0,       32'h0,     0, 1));

    // reset then idle
    do_reset(2);
    #1;
    check("reset_stall",   32'(stall_o),   32'h0);
    check("reset_pending", pending_o,      32'h0);
    check("reset_busy",    32'(busy_o),    32'h0);
    check("reset_err",     32'(err_o),     32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.iv, v.ir, v.iwe, v.ird, v.fl, v.rs1, v.u1, v.rs2, v.u2, v.wwe, v.wrd);
      #1;
      check($sformatf("vec%0d_stall", i),   32'(stall_o), 32'(v.e_stall));
      check($sformatf("vec%0d_pending", i), pending_o,    v.e_pend);
      check($sformatf("vec%0d_busy", i),    32'(busy_o),  32'(v.e_busy));
      check($sformatf("vec%0d_err", i),     32'(err_o),   32'(v.e_err));
    end

    // mid-operation reset drops counts; the orphaned writeback then flags err
    do_reset(1);
    @(negedge clk);
    drive(1, 1, 1, 5'd6, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0);
    @(negedge clk);
    idle();
    #1;
    check("midrst_pre_pending", pending_o, 32'h40);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_pending", pending_o,   32'h0);
    check("midrst_busy",    32'(busy_o), 32'h0);
    check("midrst_err",     32'(err_o),  32'h0);
    @(negedge clk);
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd6);
    @(negedge clk);
    idle();
    #1;
    check("midrst_late_wb_err", 32'(err_o), 32'h1);
    check("midrst_late_wb_pend", pending_o, 32'h0);

    // randomized run against the model
    do_reset(2);
    m_clear();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst             = ($urandom_range(0, 249) != 0);
      issue_valid_i   = ($urandom_range(0, 3) != 0);
      issue_ready_i   = ($urandom_range(0, 3) != 0);
      issue_we_rd_i   = ($urandom_range(0, 4) != 0);
      issue_rd_addr_i = 5'($urandom_range(0, 7));
      flush_i         = ($urandom_range(0, 9) == 0);
      rs1_addr_i      = 5'($urandom_range(0, 7));
      rs1_used_i      = $urandom_range(0, 1);
      rs2_addr_i      = 5'($urandom_range(0, 7));
      rs2_used_i      = $urandom_range(0, 1);
      wb_we_rd_i      = ($urandom_range(0, 9) < 4);
      pend_q.delete();
      for (int r = 1; r < 32; r++) if (mcnt[r] > 0) pend_q.push_back(r);
      if (pend_q.size() > 0 && $urandom_range(0, 99) < 90)
        wb_rd_addr_i = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
      else
        wb_rd_addr_i = 5'($urandom_range(0, 7));
      #1;
      check("rand_stall",   32'(stall_o), 32'(m_stall()));
      check("rand_pending", pending_o,    m_pend());
      check("rand_busy",    32'(busy_o),  32'(mtot != 0));
      check("rand_err",     32'(err_o),   32'(merr));
      m_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
